// File: rtl/regfile_write_port.sv
// regfile_write_port
// Write side of the three-read-port register file: a 5-to-32 binary decoder
// driving 32 load-enabled WIDTH-bit registers whose contents feed the read
// multiplexers. Register 0 can be hardwired to zero (SPARC convention).
//
// Ports:
//   clk      in   rising-edge system clock
//   reset    in   synchronous active-high reset (clears all registers, wr_ack)
//   we       in   write enable from the write-back stage
//   waddr    in   destination register number (5 bits)
//   wdata    in   data to write (WIDTH bits)
//   wr_ack   out  registered pulse: a write was committed on the previous edge
//   dec_out  out  combinational one-hot decode of waddr gated by we
//   Q0..Q31  out  current register contents (WIDTH bits each)
module regfile_write_port #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic             wr_ack,
    output logic [31:0]      dec_out,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7,
    output logic [WIDTH-1:0] Q8,
    output logic [WIDTH-1:0] Q9,
    output logic [WIDTH-1:0] Q10,
    output logic [WIDTH-1:0] Q11,
    output logic [WIDTH-1:0] Q12,
    output logic [WIDTH-1:0] Q13,
    output logic [WIDTH-1:0] Q14,
    output logic [WIDTH-1:0] Q15,
    output logic [WIDTH-1:0] Q16,
    output logic [WIDTH-1:0] Q17,
    output logic [WIDTH-1:0] Q18,
    output logic [WIDTH-1:0] Q19,
    output logic [WIDTH-1:0] Q20,
    output logic [WIDTH-1:0] Q21,
    output logic [WIDTH-1:0] Q22,
    output logic [WIDTH-1:0] Q23,
    output logic [WIDTH-1:0] Q24,
    output logic [WIDTH-1:0] Q25,
    output logic [WIDTH-1:0] Q26,
    output logic [WIDTH-1:0] Q27,
    output logic [WIDTH-1:0] Q28,
    output logic [WIDTH-1:0] Q29,
    output logic [WIDTH-1:0] Q30,
    output logic [WIDTH-1:0] Q31
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] ld;

    // Each decode bit is an explicit compare ANDed with we, so an unknown
    // waddr while we=0 still yields an all-zero decode and no load.
    always_comb begin
        dec_out = '0;
        for (int i = 0; i < 32; i++) begin
            dec_out[i] = we && (waddr == 5'(i));
        end
    end

    // Load enables follow the decoder, with R0 masked when it is hardwired.
    always_comb begin
        ld = dec_out[NREGS-1:0];
        if (ZERO_REG != 0) begin
            ld[0] = 1'b0;
        end
    end

    // Register bank and write acknowledge. Reset takes priority over any
    // write in the same edge. A write counts as committed exactly when some
    // load enable fired, which is why wr_ack is simply the OR of ld.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wr_ack <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ld[i]) begin
                    regs[i] <= wdata;
                end
            end
            wr_ack <= |ld;
        end
    end

    assign Q0  = regs[0];   assign Q1  = regs[1];   assign Q2  = regs[2];   assign Q3  = regs[3];
    assign Q4  = regs[4];   assign Q5  = regs[5];   assign Q6  = regs[6];   assign Q7  = regs[7];
    assign Q8  = regs[8];   assign Q9  = regs[9];   assign Q10 = regs[10];  assign Q11 = regs[11];
    assign Q12 = regs[12];  assign Q13 = regs[13];  assign Q14 = regs[14];  assign Q15 = regs[15];
    assign Q16 = regs[16];  assign Q17 = regs[17];  assign Q18 = regs[18];  assign Q19 = regs[19];
    assign Q20 = regs[20];  assign Q21 = regs[21];  assign Q22 = regs[22];  assign Q23 = regs[23];
    assign Q24 = regs[24];  assign Q25 = regs[25];  assign Q26 = regs[26];  assign Q27 = regs[27];
    assign Q28 = regs[28];  assign Q29 = regs[29];  assign Q30 = regs[30];  assign Q31 = regs[31];

endmodule

// File: tb/tb_regfile_write_port.sv
// tb_regfile_write_port
// Drives two instances of regfile_write_port with identical stimulus: one
// with R0 hardwired to zero (a) and one with R0 as an ordinary register (b).
// Expected register contents come from a plain array model of the register
// file; directed vectors also carry constant expectations.
module tb_regfile_write_port;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wr_ack_a, wr_ack_b;
    logic [31:0] dec_out_a, dec_out_b;
    logic [31:0] qa [32];
    logic [31:0] qb [32];

    logic [31:0] model_a [32];
    logic [31:0] model_b [32];
    logic        ack_a_exp, ack_b_exp;

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {
        logic        rst;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] dec;
        logic        ack_a;
        logic        ack_b;
        logic        chk_en;
        logic [31:0] chk_val;
    } vec_t;

    vec_t vecs[$];

    regfile_write_port #(.WIDTH(32), .NREGS(32), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .wr_ack(wr_ack_a), .dec_out(dec_out_a),
        .Q0(qa[0]),   .Q1(qa[1]),   .Q2(qa[2]),   .Q3(qa[3]),   .Q4(qa[4]),   .Q5(qa[5]),
        .Q6(qa[6]),   .Q7(qa[7]),   .Q8(qa[8]),   .Q9(qa[9]),   .Q10(qa[10]), .Q11(qa[11]),
        .Q12(qa[12]), .Q13(qa[13]), .Q14(qa[14]), .Q15(qa[15]), .Q16(qa[16]), .Q17(qa[17]),
        .Q18(qa[18]), .Q19(qa[19]), .Q20(qa[20]), .Q21(qa[21]), .Q22(qa[22]), .Q23(qa[23]),
        .Q24(qa[24]), .Q25(qa[25]), .Q26(qa[26]), .Q27(qa[27]), .Q28(qa[28]), .Q29(qa[29]),
        .Q30(qa[30]), .Q31(qa[31])
    );

    regfile_write_port #(.WIDTH(32), .NREGS(32), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .wr_ack(wr_ack_b), .dec_out(dec_out_b),
        .Q0(qb[0]),   .Q1(qb[1]),   .Q2(qb[2]),   .Q3(qb[3]),   .Q4(qb[4]),   .Q5(qb[5]),
        .Q6(qb[6]),   .Q7(qb[7]),   .Q8(qb[8]),   .Q9(qb[9]),   .Q10(qb[10]), .Q11(qb[11]),
        .Q12(qb[12]), .Q13(qb[13]), .Q14(qb[14]), .Q15(qb[15]), .Q16(qb[16]), .Q17(qb[17]),
        .Q18(qb[18]), .Q19(qb[19]), .Q20(qb[20]), .Q21(qb[21]), .Q22(qb[22]), .Q23(qb[23]),
        .Q24(qb[24]), .Q25(qb[25]), .Q26(qb[26]), .Q27(qb[27]), .Q28(qb[28]), .Q29(qb[29]),
        .Q30(qb[30]), .Q31(qb[31])
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check the combinational decode, then let the
    // edge happen and advance the array model by the register-file rules.
    task automatic applyStimulus(input logic r, input logic w, input logic [4:0] a,
                                 input logic [31:0] d, input logic [31:0] exp_dec);
        reset = r;
        we    = w;
        waddr = a;
        wdata = d;
        #1;
        checkVal("dec_out_a", dec_out_a, exp_dec);
        checkVal("dec_out_b", dec_out_b, exp_dec);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                model_a[i] = '0;
                model_b[i] = '0;
            end
            ack_a_exp = 1'b0;
            ack_b_exp = 1'b0;
        end else begin
            if (w) begin
                model_b[a] = d;
                if (a != 5'd0) model_a[a] = d;
            end
            ack_a_exp = w && (a != 5'd0);
            ack_b_exp = w;
        end
        #1;
    endtask

    // Compare both register banks and acks against the model.
    task automatic checkOutput();
        int bad_a = 0;
        int bad_b = 0;
        for (int i = 31; i >= 0; i--) begin
            if (qa[i] !== model_a[i]) bad_a = i;
            if (qb[i] !== model_b[i]) bad_b = i;
        end
        checkVal($sformatf("regs_a[%0d]", bad_a), qa[bad_a], model_a[bad_a]);
        checkVal($sformatf("regs_b[%0d]", bad_b), qb[bad_b], model_b[bad_b]);
        checkVal("wr_ack_a", {31'd0, wr_ack_a}, {31'd0, ack_a_exp});
        checkVal("wr_ack_b", {31'd0, wr_ack_b}, {31'd0, ack_b_exp});
    endtask

    function automatic vec_t mkVec(input logic rst, input logic w, input logic [4:0] a,
                                   input logic [31:0] d, input logic [31:0] dec,
                                   input logic ack_a, input logic ack_b,
                                   input logic chk_en, input logic [31:0] chk_val);
        vec_t v;
        v.rst = rst; v.w = w; v.a = a; v.d = d; v.dec = dec;
        v.ack_a = ack_a; v.ack_b = ack_b; v.chk_en = chk_en; v.chk_val = chk_val;
        return v;
    endfunction

    initial begin
        logic        r;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;

        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        ack_a_exp = 1'b0; ack_b_exp = 1'b0;
        for (int i = 0; i < 32; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end

        // Directed vector table.
        vecs.push_back(mkVec(1, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 32'h0));
        for (int i = 1; i < 32; i++) begin
            vecs.push_back(mkVec(0, 1, 5'(i), 32'hA5A50000 + 32'(i), 32'd1 << i,
                                 1, 1, 1, 32'hA5A50000 + 32'(i)));
        end
        vecs.push_back(mkVec(0, 1, 5'd5, 32'h11111111, 32'h00000020, 1, 1, 1, 32'h11111111));
        vecs.push_back(mkVec(0, 1, 5'd5, 32'h22222222, 32'h00000020, 1, 1, 1, 32'h22222222));
        vecs.push_back(mkVec(0, 1, 5'd7, 32'hFFFFFFFF, 32'h00000080, 1, 1, 1, 32'hFFFFFFFF));
        vecs.push_back(mkVec(1, 1, 5'd7, 32'h12345678, 32'h00000080, 0, 0, 1, 32'h00000000));
        vecs.push_back(mkVec(0, 1, 5'd9, 32'hFFFFFFFF, 32'h00000200, 1, 1, 1, 32'hFFFFFFFF));
        vecs.push_back(mkVec(0, 1, 5'd9, 32'h00000000, 32'h00000200, 1, 1, 1, 32'h00000000));
        vecs.push_back(mkVec(0, 0, 5'd9, 32'hCAFEF00D, 32'h00000000, 0, 0, 1, 32'h00000000));

        $display("[TB] directed table: %0d vectors", vecs.size());
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].rst, vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].dec);
            checkOutput();
            checkVal($sformatf("vec%0d_ack_a", k), {31'd0, wr_ack_a}, {31'd0, vecs[k].ack_a});
            checkVal($sformatf("vec%0d_ack_b", k), {31'd0, wr_ack_b}, {31'd0, vecs[k].ack_b});
            if (vecs[k].chk_en) begin
                checkVal($sformatf("vec%0d_q%0d", k, vecs[k].a), qa[vecs[k].a], vecs[k].chk_val);
            end
        end

        // Write to R0: hardwired instance ignores it, plain instance stores it.
        $display("[TB] R0 write sequence");
        applyStimulus(0, 1, 5'd0, 32'hDEADBEEF, 32'h00000001);
        checkOutput();
        checkVal("q0_zero_reg", qa[0], 32'h00000000);
        checkVal("q0_plain", qb[0], 32'hDEADBEEF);
        checkVal("r0_ack_zero_reg", {31'd0, wr_ack_a}, 32'd0);
        checkVal("r0_ack_plain", {31'd0, wr_ack_b}, 32'd1);

        // Load known values, then hold we=0 with random and unknown waddr/wdata.
        $display("[TB] idle sequence with we=0");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 1, 5'(i), $urandom, 32'd1 << i);
        end
        checkOutput();
        for (int c = 0; c < 50; c++) begin
            if (c % 10 == 9) applyStimulus(0, 0, 5'bxxxxx, 32'hxxxxxxxx, 32'h0);
            else             applyStimulus(0, 0, 5'($urandom_range(0, 31)), $urandom, 32'h0);
            checkOutput();
            checkVal("idle_ack", {31'd0, wr_ack_a | wr_ack_b}, 32'd0);
        end

        // Random mixed traffic with occasional mid-stream reset.
        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 3) != 0);
            a = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0:       d = 32'hFFFFFFFF;
                1:       d = 32'h00000000;
                default: d = $urandom;
            endcase
            applyStimulus(r, w, a, d, w ? (32'd1 << a) : 32'd0);
            checkOutput();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
